// File: rtl/chan_stim_pkg.sv
// Shared types and PRBS7 helpers for the channel stimulus generator.
package chan_stim_pkg;

   localparam int PRBS_TAP_A = 6;
   localparam int PRBS_TAP_B = 5;
   localparam logic [6:0] PRBS_SEED_DEF = 7'h7F;

   localparam int LEVEL_W = 16;
   typedef logic signed [LEVEL_W-1:0] level_t;

   typedef struct packed {
      logic [6:0] state;
      logic       nb;
   } prbs_step_t;

   // x^7 + x^6 + 1: new bit shifts in at the LSB
   function automatic prbs_step_t prbs7_next(input logic [6:0] s);
      prbs_step_t r;
      r.nb    = s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
      r.state = {s[5:0], r.nb};
      return r;
   endfunction

endpackage

// File: rtl/chan_stim_gen_lfsr.sv
// PRBS7 state register with shift enable and synchronous seed load.
module prbs7_lfsr
   import chan_stim_pkg::*;
(
   input  logic       clk,
   input  logic       load_i,
   input  logic       shift_i,
   input  logic [6:0] seed_i,
   output logic       nb_o
);

   logic [6:0] lfsr_q;
   logic [6:0] lfsr_d;
   prbs_step_t step;

   always_comb begin
      step   = prbs7_next(lfsr_q);
      lfsr_d = lfsr_q;
      if (load_i)
         lfsr_d = seed_i;
      else if (shift_i)
         lfsr_d = step.state;
   end

   always_ff @(posedge clk) begin
      lfsr_q <= lfsr_d;
   end

   assign nb_o = step.nb;

endmodule

// File: rtl/chan_stim_gen.sv
// Adaptive-step stimulus source: steps never straddle a symbol boundary,
// so level changes always land on a step edge.
module chan_stim_gen
   import chan_stim_pkg::*;
#(
   parameter int         DT_WIDTH = 16,
   parameter int         IN_WIDTH = 16,
   parameter int         UI       = 1000,
   parameter int         DT_MAX   = 250,
   parameter int         AMP      = 8192,
   parameter logic [6:0] SEED     = PRBS_SEED_DEF
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       pat_sel,
   output logic [DT_WIDTH-1:0]        dt,
   output logic signed [IN_WIDTH-1:0] in_,
   output logic                       sym_edge,
   output logic [31:0]                sym_count
);

   localparam logic [DT_WIDTH-1:0] UI_C  = DT_WIDTH'(UI);
   localparam logic [DT_WIDTH-1:0] DTM_C = DT_WIDTH'(DT_MAX);
   localparam logic signed [IN_WIDTH-1:0] AMP_P = IN_WIDTH'(AMP);
   localparam logic signed [IN_WIDTH-1:0] AMP_N = -AMP_P;
   // An all-zero seed would lock the LFSR up
   localparam logic [6:0] SEED_C = (SEED == 7'h00) ? 7'h01 : SEED;

   logic [DT_WIDTH-1:0]        t_rem_q, t_rem_d;
   logic signed [IN_WIDTH-1:0] level_q, level_d;
   logic [31:0]                cnt_q, cnt_d;
   logic                       edge_q, edge_d;

   logic [DT_WIDTH-1:0] dt_w;
   logic [DT_WIDTH-1:0] t_next;
   logic                bound;
   logic                nb;

   assign dt_w   = !en ? '0 :
                   (t_rem_q < DTM_C) ? t_rem_q : DTM_C;
   assign t_next = t_rem_q - dt_w;
   assign bound  = en && (t_next == '0);

   prbs7_lfsr u_lfsr (
      .clk     (clk),
      .load_i  (rst),
      .shift_i (bound),
      .seed_i  (SEED_C),
      .nb_o    (nb)
   );

   always_comb begin
      t_rem_d = t_rem_q;
      level_d = level_q;
      cnt_d   = cnt_q;
      edge_d  = edge_q;
      if (en) begin
         if (!bound) begin
            t_rem_d = t_next;
            edge_d  = 1'b0;
         end else begin
            level_d = (pat_sel || nb) ? AMP_P : AMP_N;
            t_rem_d = UI_C;
            cnt_d   = cnt_q + 32'd1;
            edge_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t_rem_q <= UI_C;
         level_q <= (pat_sel || SEED_C[0]) ? AMP_P : AMP_N;
         cnt_q   <= '0;
         edge_q  <= 1'b1;
      end else begin
         t_rem_q <= t_rem_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         edge_q  <= edge_d;
      end
   end

   assign dt        = dt_w;
   assign in_       = level_q;
   assign sym_edge  = edge_q & en;
   assign sym_count = cnt_q;

endmodule

// File: tb/tb_chan_stim_gen.sv
// Scoreboard bench: four generator configurations driven in lockstep.
module tb_chan_stim_gen;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en = 1'b0;
   logic pat_sel = 1'b0;

   logic [15:0]        dt_w[4];
   logic signed [15:0] in_w[4];
   logic               edge_w[4];
   logic [31:0]        cnt_w[4];

   always #5 clk = ~clk;

   chan_stim_gen #(.UI(100), .DT_MAX(30), .SEED(7'h7F)) u_a (
      .clk(clk), .rst(rst), .en(en), .pat_sel(pat_sel),
      .dt(dt_w[0]), .in_(in_w[0]), .sym_edge(edge_w[0]),
      .sym_count(cnt_w[0]));
   chan_stim_gen #(.UI(20), .DT_MAX(30), .SEED(7'h7F)) u_b (
      .clk(clk), .rst(rst), .en(en), .pat_sel(pat_sel),
      .dt(dt_w[1]), .in_(in_w[1]), .sym_edge(edge_w[1]),
      .sym_count(cnt_w[1]));
   chan_stim_gen #(.UI(1), .DT_MAX(1), .SEED(7'h7F)) u_c (
      .clk(clk), .rst(rst), .en(en), .pat_sel(pat_sel),
      .dt(dt_w[2]), .in_(in_w[2]), .sym_edge(edge_w[2]),
      .sym_count(cnt_w[2]));
   chan_stim_gen #(.UI(1), .DT_MAX(1), .SEED(7'h00)) u_d (
      .clk(clk), .rst(rst), .en(en), .pat_sel(pat_sel),
      .dt(dt_w[3]), .in_(in_w[3]), .sym_edge(edge_w[3]),
      .sym_count(cnt_w[3]));

   typedef struct {
      int          t_rem;
      bit          edg;
      int unsigned cnt;
      bit [6:0]    lfsr;
      bit          pos;
   } m_t;

   typedef struct {
      int          k;
      int          dt;
      bit          edg;
      int unsigned cnt;
      int          lvl;
   } exp_t;

   int ui_p[4]  = '{100, 20, 1, 1};
   int dtm_p[4] = '{30, 30, 1, 1};
   bit [6:0] seed_p[4] = '{7'h7F, 7'h7F, 7'h7F, 7'h01};

   m_t   m[4];
   bit   mv = 1'b0;
   exp_t exp_q[$];

   int          cap_dt[4];
   bit          cap_edge[4];
   int unsigned cap_cnt[4];
   int          cap_in[4];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input longint o, input longint e);
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, o, e);
      end
   endtask

   function automatic exp_t model_out(input int k, input bit e);
      exp_t x;
      x.k   = k;
      x.dt  = !e ? 0 : (m[k].t_rem < dtm_p[k] ? m[k].t_rem : dtm_p[k]);
      x.edg = m[k].edg & e;
      x.cnt = m[k].cnt;
      x.lvl = m[k].pos ? 8192 : -8192;
      return x;
   endfunction

   function automatic void model_step(input int k, input bit r,
                                      input bit e, input bit p);
      int d;
      bit nb;
      if (r) begin
         m[k].t_rem = ui_p[k];
         m[k].lfsr  = seed_p[k];
         m[k].pos   = p | seed_p[k][0];
         m[k].cnt   = 0;
         m[k].edg   = 1'b1;
      end else if (e) begin
         d = (m[k].t_rem < dtm_p[k]) ? m[k].t_rem : dtm_p[k];
         if (m[k].t_rem - d != 0) begin
            m[k].t_rem = m[k].t_rem - d;
            m[k].edg   = 1'b0;
         end else begin
            nb = m[k].lfsr[6] ^ m[k].lfsr[5];
            m[k].lfsr  = {m[k].lfsr[5:0], nb};
            m[k].pos   = p | nb;
            m[k].t_rem = ui_p[k];
            m[k].cnt   = m[k].cnt + 1;
            m[k].edg   = 1'b1;
         end
      end
   endfunction

   task automatic cycle(input bit r, input bit e, input bit p);
      exp_t x;
      @(negedge clk);
      rst = r;
      en = e;
      pat_sel = p;
      if (mv)
         for (int k = 0; k < 4; k++)
            exp_q.push_back(model_out(k, e));
      #1;
      for (int k = 0; k < 4; k++) begin
         cap_dt[k]   = int'(dt_w[k]);
         cap_edge[k] = edge_w[k];
         cap_cnt[k]  = cnt_w[k];
         cap_in[k]   = int'(in_w[k]);
      end
      while (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         chk($sformatf("dt%0d", x.k), cap_dt[x.k], x.dt);
         chk($sformatf("edge%0d", x.k), cap_edge[x.k], x.edg);
         chk($sformatf("cnt%0d", x.k), cap_cnt[x.k], x.cnt);
         chk($sformatf("in%0d", x.k), cap_in[x.k], x.lvl);
      end
      @(posedge clk);
      for (int k = 0; k < 4; k++)
         model_step(k, r, e, p);
      if (r)
         mv = 1'b1;
   endtask

   int pat[4] = '{30, 30, 30, 10};
   bit sgn[254];
   int ones;
   int sum;
   int nres;
   bit done;

   initial begin
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b1);

      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 1'b1, 1'b1);
         chk("a_dtseq", cap_dt[0], pat[i % 4]);
         chk("a_edge", cap_edge[0], (i % 4) == 0);
         chk("a_in", cap_in[0], 8192);
         chk("b_dt", cap_dt[1], 20);
         chk("b_edge", cap_edge[1], 1);
         chk("b_cnt", cap_cnt[1], i);
      end
      cycle(1'b0, 1'b1, 1'b1);
      chk("a_cnt12", cap_cnt[0], 3);

      cycle(1'b1, 1'b1, 1'b1);
      sum = 0;
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 1'b1, 1'b1);
         sum += cap_dt[0];
      end
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b0, 1'b1);
         chk("hold_dt", cap_dt[0], 0);
         chk("hold_edge", cap_edge[0], 0);
      end
      done = 1'b0;
      nres = 0;
      for (int i = 0; i < 10 && !done; i++) begin
         cycle(1'b0, 1'b1, 1'b1);
         if (cap_cnt[0] == 1) begin
            done = 1'b1;
         end else begin
            chk("resume_dt", cap_dt[0], nres == 0 ? 30 : 10);
            nres++;
            sum += cap_dt[0];
         end
      end
      chk("resume_done", done, 1);
      chk("resume_steps", nres, 2);
      chk("sym_sum", sum, 100);

      cycle(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 254; i++) begin
         cycle(1'b0, 1'b1, 1'b0);
         sgn[i] = cap_in[2] > 0;
      end
      ones = 0;
      for (int i = 0; i < 127; i++) begin
         chk("prbs_period", sgn[i + 127], sgn[i]);
         ones += int'(sgn[i]);
      end
      chk("prbs_ones", ones, 64);

      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      chk("rst_dt", cap_dt[0], 30);
      chk("rst_edge", cap_edge[0], 1);
      chk("rst_cnt", cap_cnt[0], 0);
      chk("rst_in", cap_in[0], 8192);
      for (int i = 0; i < 20; i++)
         cycle(1'b0, 1'b1, i[2]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
